pid_ctrl_pipe: RTL and testbench

PID_CTRL_PIPE -- requirements
Module: pid_ctrl_pipe

---
 rtl/pid_ctrl_pipe_pkg.sv | 24 ++
 rtl/pid_ctrl_pipe_if.sv | 41 ++++
 rtl/pid_ctrl_pipe_sat.sv | 37 +++
 rtl/pid_ctrl_pipe.sv | 190 +++++++++++++++++++
 tb/tb_pid_ctrl_pipe.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_ctrl_pipe_pkg.sv
// ----------------------------------------------------------------------------
// pid_pkg
// Shared constants for the pid_ctrl_pipe heading controller: default
// parameter values, derivative clamp width, integrator tap position and the
// final PID scaling shift.
// Ports: none (package).
// ----------------------------------------------------------------------------
package pid_pkg;

    localparam int unsigned ERR_W_DEF   = 12;
    localparam int unsigned SAT_W_DEF   = 10;
    localparam int unsigned FRWRD_W_DEF = 10;
    localparam int          P_COEFF_DEF = 8;
    localparam int          D_COEFF_DEF = 11;
    localparam int unsigned D_DLY_DEF   = 2;

    // Derivative term is clamped to this signed width before scaling.
    localparam int unsigned DIFF_W      = 7;
    // PID sum is arithmetically shifted right by this amount.
    localparam int unsigned PID_SHIFT   = 3;
    // I term is the integrator with this many LSBs dropped.
    localparam int unsigned INT_SHIFT   = 6;

endpackage

// File: rtl/pid_ctrl_pipe_if.sv
// ----------------------------------------------------------------------------
// pid_ctrl_pipe_if
// Bundles the controller's sample input and wheel-speed output signals.
// Ports (signals):
//   moving   - control enable; low clears controller state
//   err_vld  - one-cycle qualifier for a new error sample
//   error    - signed heading error, ERR_W bits
//   frwrd    - unsigned forward speed, FRWRD_W bits
//   lft_spd  - signed left wheel speed, FRWRD_W+1 bits
//   rght_spd - signed right wheel speed, FRWRD_W+1 bits
//   spd_vld  - one-cycle pulse marking new speeds
// Modports: master drives samples, slave (the controller) drives speeds.
// ----------------------------------------------------------------------------
interface pid_ctrl_pipe_if
    import pid_pkg::*;
#(
    parameter int unsigned ERR_W   = ERR_W_DEF,
    parameter int unsigned FRWRD_W = FRWRD_W_DEF
);

    localparam int unsigned SPD_W = FRWRD_W + 1;

    logic               moving;
    logic               err_vld;
    logic [ERR_W-1:0]   error;
    logic [FRWRD_W-1:0] frwrd;
    logic [SPD_W-1:0]   lft_spd;
    logic [SPD_W-1:0]   rght_spd;
    logic               spd_vld;

    modport master (
        output moving, err_vld, error, frwrd,
        input  lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  moving, err_vld, error, frwrd,
        output lft_spd, rght_spd, spd_vld
    );

endinterface

// File: rtl/pid_ctrl_pipe_sat.sv
// ----------------------------------------------------------------------------
// sat_signed
// Clamps a signed IN_W-bit value to the signed OUT_W-bit range
// (-2^(OUT_W-1) .. 2^(OUT_W-1)-1). Purely combinational; IN_W >= OUT_W.
// Ports:
//   din_i  - signed input, IN_W bits
//   dout_o - signed clamped output, OUT_W bits
// ----------------------------------------------------------------------------
module sat_signed #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

    generate
        if (IN_W == OUT_W) begin : g_pass
            assign dout_o = din_i;
        end else begin : g_clamp
            localparam logic signed [IN_W-1:0] MAX_V =
                {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

            always_comb begin
                if (din_i > MAX_V) begin
                    dout_o = MAX_V[OUT_W-1:0];
                end else if (din_i < MIN_V) begin
                    dout_o = MIN_V[OUT_W-1:0];
                end else begin
                    dout_o = din_i[OUT_W-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pid_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// pid_ctrl_pipe
// Two-stage pipelined PID heading controller for a differential drive.
// Each qualified error sample is saturated and turned into P, I and D terms
// (stage 1); stage 2 sums them, scales by 2^-PID_SHIFT and steers the
// forward speed into clamped left/right wheel speeds. One sample per cycle,
// fixed two-edge latency, no stall.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pid_ctrl_pipe_if.slave: moving, err_vld, error, frwrd in;
//           lft_spd, rght_spd, spd_vld out (all outputs registered)
// ----------------------------------------------------------------------------
module pid_ctrl_pipe
    import pid_pkg::*;
#(
    parameter int unsigned ERR_W   = ERR_W_DEF,
    parameter int unsigned SAT_W   = SAT_W_DEF,
    parameter int unsigned FRWRD_W = FRWRD_W_DEF,
    parameter int          P_COEFF = P_COEFF_DEF,
    parameter int          D_COEFF = D_COEFF_DEF,
    parameter int unsigned D_DLY   = D_DLY_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pid_ctrl_pipe_if.slave bus
);

    localparam int unsigned SPD_W = FRWRD_W + 1;
    localparam int unsigned PW    = SAT_W + 4;             // P/I/D/PID width
    localparam int unsigned IW    = SAT_W + 5;             // integrator width
    localparam int unsigned IQ_W  = IW - INT_SHIFT;        // I term width
    localparam int unsigned DF_W  = SAT_W + 1;             // raw difference
    localparam int unsigned SUM_W = ((PW > SPD_W) ? PW : SPD_W) + 1;

    localparam logic signed [PW-1:0] P_C = PW'(P_COEFF);
    localparam logic signed [PW-1:0] D_C = PW'(D_COEFF);

    // ---------------------------------------------------------------- inputs
    logic signed [ERR_W-1:0] err_in;
    logic signed [SAT_W-1:0] err_sat;
    logic                    sample;

    assign err_in = bus.error;
    assign sample = bus.err_vld & bus.moving;

    sat_signed #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_sat_err (
        .din_i  (err_in),
        .dout_o (err_sat)
    );

    // -------------------------------------------------------------- P term
    logic signed [PW-1:0] err_sat_p;
    logic signed [PW-1:0] p_d;

    assign err_sat_p = {{(PW-SAT_W){err_sat[SAT_W-1]}}, err_sat};
    assign p_d       = err_sat_p * P_C;

    // --------------------------------------------------- integrator, I term
    logic signed [IW-1:0] err_sat_i;
    logic signed [IW-1:0] integ_q, integ_d, integ_sum;
    logic                 integ_ovf;
    logic signed [PW-1:0] i_d;

    assign err_sat_i = {{(IW-SAT_W){err_sat[SAT_W-1]}}, err_sat};
    assign integ_sum = integ_q + err_sat_i;
    // Same-sign operands producing a result of the other sign: hold instead.
    assign integ_ovf = (integ_q[IW-1] == err_sat_i[IW-1]) &&
                       (integ_sum[IW-1] != integ_q[IW-1]);
    // I uses the integrator value before this edge's accumulation.
    assign i_d = {{(PW-IQ_W){integ_q[IW-1]}}, integ_q[IW-1:INT_SHIFT]};

    // ----------------------------------------------- history, D term
    logic signed [SAT_W-1:0]  hist_q [D_DLY];
    logic signed [SAT_W-1:0]  hist_d [D_DLY];
    logic signed [SAT_W-1:0]  oldest;
    logic signed [DF_W-1:0]   diff_full;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PW-1:0]     diff_p;
    logic signed [PW-1:0]     d_d;

    assign oldest    = hist_q[D_DLY-1];
    assign diff_full = {err_sat[SAT_W-1], err_sat} - {oldest[SAT_W-1], oldest};

    sat_signed #(.IN_W(DF_W), .OUT_W(DIFF_W)) u_sat_diff (
        .din_i  (diff_full),
        .dout_o (diff)
    );

    assign diff_p = {{(PW-DIFF_W){diff[DIFF_W-1]}}, diff};
    assign d_d    = diff_p * D_C;

    always_comb begin
        integ_d = integ_q;
        hist_d  = hist_q;
        if (sample) begin
            if (!integ_ovf) begin
                integ_d = integ_sum;
            end
            hist_d[0] = err_sat;
            for (int unsigned k = 1; k < D_DLY; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            hist_q  <= '{default: '0};
        end else if (!bus.moving) begin
            integ_q <= '0;
            hist_q  <= '{default: '0};
        end else begin
            integ_q <= integ_d;
            hist_q  <= hist_d;
        end
    end

    // ------------------------------------------------------------- stage 1
    logic signed [PW-1:0] p_q, i_q, d_q;
    logic                 v1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            i_q  <= '0;
            d_q  <= '0;
            v1_q <= 1'b0;
        end else if (!bus.moving) begin
            p_q  <= '0;
            i_q  <= '0;
            d_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= sample;
            if (sample) begin
                p_q <= p_d;
                i_q <= i_d;
                d_q <= d_d;
            end
        end
    end

    // ------------------------------------------------------------- stage 2
    logic signed [PW-1:0]    pid, sh;
    logic signed [SUM_W-1:0] frwrd_ext, sh_ext, lft_full, rght_full;
    logic signed [SPD_W-1:0] lft_d, rght_d, lft_q, rght_q;
    logic                    vld_q;

    assign pid       = p_q + i_q + d_q;
    assign sh        = pid >>> PID_SHIFT;
    assign frwrd_ext = {{(SUM_W-FRWRD_W){1'b0}}, bus.frwrd};
    assign sh_ext    = {{(SUM_W-PW){sh[PW-1]}}, sh};
    assign lft_full  = frwrd_ext + sh_ext;
    assign rght_full = frwrd_ext - sh_ext;

    sat_signed #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_lft (
        .din_i  (lft_full),
        .dout_o (lft_d)
    );

    sat_signed #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_rght (
        .din_i  (rght_full),
        .dout_o (rght_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= '0;
            rght_q <= '0;
            vld_q  <= 1'b0;
        end else if (!bus.moving) begin
            lft_q  <= '0;
            rght_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= v1_q;
            if (v1_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
        end
    end

    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.spd_vld  = vld_q;

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
module tb_pid_ctrl_pipe;

    localparam int ERR_W   = 12;
    localparam int FRWRD_W = 10;

    logic clk;
    logic rst_n;

    pid_ctrl_pipe_if #(.ERR_W(ERR_W), .FRWRD_W(FRWRD_W)) bus ();

    pid_ctrl_pipe #(
        .ERR_W   (12),
        .SAT_W   (10),
        .FRWRD_W (10),
        .P_COEFF (8),
        .D_COEFF (11),
        .D_DLY   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------ behavioural model
    typedef struct {
        int due;
        int pid;
    } pend_t;

    int    m_integ;
    int    m_hist[$];     // front = oldest sample
    pend_t m_pend[$];
    int    m_edge;
    int    exp_lft, exp_rght;
    int    exp_vld;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_clear();
        m_integ = 0;
        m_hist.delete();
        for (int i = 0; i < 2; i++) m_hist.push_back(0);
        m_pend.delete();
        exp_lft  = 0;
        exp_rght = 0;
        exp_vld  = 0;
    endtask

    task automatic model_edge();
        int es, p, iv, d, pid, n, sh, fw;
        pend_t e;
        m_edge++;
        if (!bus.moving) begin
            model_clear();
            return;
        end
        fw = int'(bus.frwrd);
        exp_vld = 0;
        if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
            e  = m_pend.pop_front();
            sh = e.pid >>> 3;
            exp_lft  = clamp(fw + sh, -1024, 1023);
            exp_rght = clamp(fw - sh, -1024, 1023);
            exp_vld  = 1;
        end
        if (bus.err_vld) begin
            es  = clamp(int'($signed(bus.error)), -512, 511);
            p   = es * 8;
            iv  = m_integ >>> 6;
            d   = clamp(es - m_hist[0], -64, 63) * 11;
            pid = p + iv + d;
            n   = m_integ + es;
            if (n >= -16384 && n <= 16383) m_integ = n;
            void'(m_hist.pop_front());
            m_hist.push_back(es);
            e.due = m_edge + 1;
            e.pid = pid;
            m_pend.push_back(e);
        end
    endtask

    // One clock: model steps at the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("spd_vld",  {31'b0, bus.spd_vld}, exp_vld);
        chk("lft_spd",  $signed(bus.lft_spd), exp_lft);
        chk("rght_spd", $signed(bus.rght_spd), exp_rght);
    endtask

    // ------------------------------------------------ directed vectors
    typedef struct {
        string       name;
        logic [11:0] error;
        logic [9:0]  frwrd;
        logic [10:0] lft;
        logic [10:0] rght;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"basic",     12'h020, 10'h100, 11'h14C, 11'h0B4};
        vecs[1] = '{"pos_sat",   12'h7FF, 10'h3FF, 11'h3FF, 11'h1AA};
        vecs[2] = '{"neg_sat",   12'h800, 10'h000, 11'h5A8, 11'h258};
        vecs[3] = '{"neg_floor", 12'hFFB, 10'h200, 11'h1F4, 11'h20C};

        rst_n       = 1'b0;
        bus.moving  = 1'b0;
        bus.err_vld = 1'b0;
        bus.error   = '0;
        bus.frwrd   = '0;
        m_edge      = 0;
        model_clear();

        #1;
        chk("reset_vld",  {31'b0, bus.spd_vld}, 0);
        chk("reset_lft",  $signed(bus.lft_spd), 0);
        chk("reset_rght", $signed(bus.rght_spd), 0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: each vector from cleared state, single pulse, two-edge latency.
        foreach (vecs[v]) begin
            bus.moving  = 1'b0;
            bus.err_vld = 1'b0;
            cyc();
            bus.moving = 1'b1;
            bus.frwrd  = vecs[v].frwrd;
            cyc();
            bus.err_vld = 1'b1;
            bus.error   = vecs[v].error;
            cyc();
            chk({vecs[v].name, "_vld_early"}, {31'b0, bus.spd_vld}, 0);
            bus.err_vld = 1'b0;
            cyc();
            chk({vecs[v].name, "_vld"},  {31'b0, bus.spd_vld}, 1);
            chk({vecs[v].name, "_lft"},  {21'b0, bus.lft_spd},  {21'b0, vecs[v].lft});
            chk({vecs[v].name, "_rght"}, {21'b0, bus.rght_spd}, {21'b0, vecs[v].rght});
            cyc();
            chk({vecs[v].name, "_vld_drop"}, {31'b0, bus.spd_vld}, 0);
            chk({vecs[v].name, "_lft_hold"}, {21'b0, bus.lft_spd}, {21'b0, vecs[v].lft});
        end

        // Anti-windup: 40 back-to-back samples of 511.
        bus.moving  = 1'b0;
        bus.err_vld = 1'b0;
        cyc();
        bus.moving = 1'b1;
        bus.frwrd  = '0;
        bus.error  = 12'h1FF;
        bus.err_vld = 1'b1;
        for (int k = 0; k < 40; k++) cyc();
        bus.err_vld = 1'b0;
        cyc();
        chk("windup_vld",   {31'b0, bus.spd_vld}, 1);
        chk("windup_lft",   $signed(bus.lft_spd), 542);
        chk("windup_rght",  $signed(bus.rght_spd), -542);
        chk("windup_integ", $signed(dut.integ_q), 16352);
        cyc();

        // Sample in flight when moving drops.
        bus.err_vld = 1'b1;
        bus.error   = 12'h020;
        bus.frwrd   = 10'h100;
        cyc();
        bus.err_vld = 1'b0;
        bus.moving  = 1'b0;
        cyc();
        chk("stop_vld",   {31'b0, bus.spd_vld}, 0);
        chk("stop_lft",   $signed(bus.lft_spd), 0);
        chk("stop_rght",  $signed(bus.rght_spd), 0);
        chk("stop_integ", $signed(dut.integ_q), 0);
        bus.moving = 1'b1;
        cyc();
        chk("stop_no_vld", {31'b0, bus.spd_vld}, 0);
        // err_vld ignored while stopped.
        bus.moving  = 1'b0;
        bus.err_vld = 1'b1;
        cyc();
        bus.err_vld = 1'b0;
        bus.moving  = 1'b1;
        cyc();
        chk("ignored_vld", {31'b0, bus.spd_vld}, 0);

        // Asynchronous reset mid-pipeline.
        bus.err_vld = 1'b1;
        bus.error   = 12'h020;
        cyc();
        cyc();
        chk("pre_rst_vld", {31'b0, bus.spd_vld}, 1);
        bus.err_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld",  {31'b0, bus.spd_vld}, 0);
        chk("async_rst_lft",  $signed(bus.lft_spd), 0);
        chk("async_rst_rght", $signed(bus.rght_spd), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rst_discard_vld", {31'b0, bus.spd_vld}, 0);
        cyc();

        // Randomized run against the model.
        for (int k = 0; k < 600; k++) begin
            bus.moving  = ($urandom_range(0, 24) != 0);
            bus.err_vld = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) != 0)
                bus.error = 12'($signed($urandom_range(0, 200)) - 100);
            else
                bus.error = 12'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.frwrd = 10'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
